fsm_jump_driver: RTL

//  Initiator side of the jump/dout handshake: issues single-cycle jump pulses to an fsm responder.

---
 rtl/fsm_drv_pkg.sv | 21 ++
 rtl/cyc_down_cnt.sv | 28 ++
 rtl/fsm_jump_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fsm_drv_pkg.sv
// Shared definitions for the jump/dout handshake initiator: state encoding and
// the default response timeout.
package fsm_drv_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GAP   = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        GAP   = ST_GAP,
        PULSE = ST_PULSE,
        WAIT  = ST_WAIT,
        FIN   = ST_FIN
    } state_t;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/cyc_down_cnt.sv
// Loadable down counter that parks at zero; zero flags the parked condition.
module cyc_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fsm_jump_driver.sv
// Initiator for the jump/dout handshake: issues cmd_num jump pulses, each after cmd_gap idle
// cycles, and counts responder changes on {dout_p,dout_q}. Define JUMP_TIMEOUT_EN for the response timeout.
module fsm_jump_driver
    import fsm_drv_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
`ifdef JUMP_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_num,
    input  logic [GAP_W-1:0] cmd_gap,
    output logic             jump,
    input  logic             dout_p,
    input  logic             dout_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] ack_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] num_q;
    logic [GAP_W-1:0] gap_q;
    logic [1:0]       snap;
    logic             accept;
    logic             resp;
    logic [CNT_W-1:0] ack_inc;
    logic             ack_last;
    logic             gap_load;
    logic             gap_zero;
    logic             tmo_expire;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // A response is any difference from the value captured as PULSE was left.
    assign resp     = (state == WAIT) && ({dout_p, dout_q} != snap);
    assign ack_inc  = ack_cnt + 1'b1;
    assign ack_last = (ack_inc == num_q);

    assign gap_load = (accept && cmd_num != '0) || (resp && !ack_last);

    cyc_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (gap_load),
        .en    (state == GAP),
        .value (accept ? cmd_gap : gap_q),
        .zero  (gap_zero)
    );

`ifdef JUMP_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic tmo_zero;

    // Loaded with TIMEOUT-1 so WAIT lasts exactly TIMEOUT cycles before giving up.
    cyc_down_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (state == PULSE),
        .en    (state == WAIT),
        .value (TMO_W'(TIMEOUT - 1)),
        .zero  (tmo_zero)
    );

    assign tmo_expire = (state == WAIT) && !resp && tmo_zero;
`else
    assign tmo_expire = 1'b0;
    assign err        = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cmd_num == '0) ? FIN : GAP;
            GAP:     if (gap_zero) state_nxt = PULSE;
            PULSE:   state_nxt = WAIT;
            WAIT: begin
                if (resp) begin
                    state_nxt = ack_last ? FIN : GAP;
                end else if (tmo_expire) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // jump and done are decoded from state_nxt and registered so both are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            jump    <= 1'b0;
            done    <= 1'b0;
            ack_cnt <= '0;
            num_q   <= '0;
            gap_q   <= '0;
            snap    <= '0;
`ifdef JUMP_TIMEOUT_EN
            err     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            jump  <= (state_nxt == PULSE);
            done  <= (state_nxt == FIN);
            if (accept) begin
                num_q   <= cmd_num;
                gap_q   <= cmd_gap;
                ack_cnt <= '0;
            end
            if (state == PULSE) begin
                snap <= {dout_p, dout_q};
            end
            if (resp) begin
                ack_cnt <= ack_inc;
            end
`ifdef JUMP_TIMEOUT_EN
            if (accept) begin
                err <= 1'b0;
            end else if (tmo_expire) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule
